// File: rtl/pll_rst_pkg.sv
// Shared definitions for the SYS_PLL reset sequencer:
// FSM state encodings and the shared counter width helper.
package pll_rst_pkg;

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_ENABLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Resets to zero; adds two cycles of latency.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// SYS_PLL reset / lock / clock-enable sequencer in front of the SoC reset.
// Optional attempt limit with FAIL state: define PLL_RETRY_LIMIT_EN.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int EN_GAP        = 16,
  parameter int NUM_CLK       = 4,
  parameter int MAX_RETRY     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock_i,
  output logic               pll_reset_o,
  output logic [NUM_CLK-1:0] pll_enclk_o,
  output logic               sys_rst_n_o,
  output logic               ready_o,
  output logic [7:0]         relock_cnt_o,
  output logic [2:0]         state_o,
  output logic               fail_o
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT,
                                STABLE_CYCLES, EN_GAP);

  localparam logic [CW-1:0] RST_END = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_END = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END = CW'(EN_GAP - 1);

  logic               lock_s;
  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic [CW-1:0]      cnt_q;
  logic [NUM_CLK-1:0] en_q;
  logic               sys_q;
  logic [7:0]         relock_q;
  logic               step_en;
  logic               retry_last;
  logic               lost;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  assign lost = !lock_s &&
                (state_q == S_ENABLE || state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    step_en = 1'b0;
    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == RST_END) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lock_s)
          state_d = S_STABLE;
        else if (cnt_q == TMO_END)
          state_d = retry_last ? S_FAIL : S_HOLD;
      end
      S_STABLE: begin
        if (!lock_s)
          state_d = S_WAIT;
        else if (cnt_q == STB_END)
          state_d = S_ENABLE;
      end
      S_ENABLE: begin
        // lock loss wins over a gap expiring this cycle
        if (!lock_s)
          state_d = S_HOLD;
        else if (cnt_q == GAP_END) begin
          if (en_q[NUM_CLK-1]) state_d = S_RUN;
          else                 step_en = 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) state_d = S_HOLD;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      en_q     <= '0;
      sys_q    <= 1'b0;
      relock_q <= '0;
    end else begin
      state_q <= state_d;
      sys_q   <= (state_d == S_RUN);
      if (state_d != state_q || step_en)
        cnt_q <= '0;
      else if (state_q != S_RUN && state_q != S_FAIL)
        cnt_q <= cnt_q + CW'(1);
      if (state_d != S_ENABLE && state_d != S_RUN)
        en_q <= '0;
      else if (state_q != S_ENABLE && state_d == S_ENABLE)
        en_q <= NUM_CLK'(1);
      else if (step_en)
        en_q <= (en_q << 1) | NUM_CLK'(1);
      if (lost && relock_q != 8'hFF)
        relock_q <= relock_q + 8'd1;
    end
  end

`ifdef PLL_RETRY_LIMIT_EN
  logic [3:0] try_q;

  assign retry_last = (try_q == 4'(MAX_RETRY - 1));
  assign fail_o     = (state_q == S_FAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      try_q <= '0;
    else if (state_d == S_RUN)
      try_q <= '0;
    else if (state_q == S_WAIT &&
             (state_d == S_HOLD || state_d == S_FAIL))
      try_q <= try_q + 4'd1;
  end
`else
  assign retry_last = 1'b0 & (MAX_RETRY > 0);
  assign fail_o     = 1'b0;
`endif

  assign pll_reset_o  = (state_q == S_HOLD) ||
                        (state_q == S_FAIL);
  assign pll_enclk_o  = en_q;
  assign sys_rst_n_o  = sys_q;
  assign ready_o      = (state_q == S_RUN);
  assign relock_cnt_o = relock_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq: bring-up, timeout, unstable lock,
// lock loss in RUN, async reset in ENABLE, optional retry limit.
module tb_pll_rst_seq;

  logic       clk;
  logic       rst_n_a, rst_n_b;
  logic       lock_a, lock_b;
  logic       prst_a, prst_b;
  logic [3:0] en_a, en_b;
  logic       sys_a, sys_b;
  logic       rdy_a, rdy_b;
  logic [7:0] rel_a, rel_b;
  logic [2:0] st_a, st_b;
  logic       fail_a, fail_b;

  int checks = 0;
  int errors = 0;

  pll_rst_seq dut_a (
    .clk          (clk),
    .rst_n        (rst_n_a),
    .pll_lock_i   (lock_a),
    .pll_reset_o  (prst_a),
    .pll_enclk_o  (en_a),
    .sys_rst_n_o  (sys_a),
    .ready_o      (rdy_a),
    .relock_cnt_o (rel_a),
    .state_o      (st_a),
    .fail_o       (fail_a)
  );

  pll_rst_seq #(
    .LOCK_TIMEOUT (100),
    .MAX_RETRY    (3)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n_b),
    .pll_lock_i   (lock_b),
    .pll_reset_o  (prst_b),
    .pll_enclk_o  (en_b),
    .sys_rst_n_o  (sys_b),
    .ready_o      (rdy_b),
    .relock_cnt_o (rel_b),
    .state_o      (st_b),
    .fail_o       (fail_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {state, pll_reset, enclk, sys_rst_n, ready, fail}
  function automatic logic [10:0] snap_a();
    return {st_a, prst_a, en_a, sys_a, rdy_a, fail_a};
  endfunction

  function automatic logic [10:0] snap_b();
    return {st_b, prst_b, en_b, sys_b, rdy_b, fail_b};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    lock_a  = 1'b0;
    lock_b  = 1'b0;
    step(3);
    checks++;
    if (snap_a() !== {3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: got %b want 00010000000", snap_a());
    end
    checks++;
    if (snap_b() !== {3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b: got %b want 00010000000", snap_b());
    end
    checks++;
    if (rel_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_relock: got %0d want 0", rel_a);
    end
  endtask

  task automatic test_bringup();
    @(negedge clk);
    rst_n_a = 1'b1;
    step(63);
    checks++;
    if ({st_a, prst_a} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL hold63: got %b want 0001", {st_a, prst_a});
    end
    step(1);
    checks++;
    if ({st_a, prst_a} !== {3'd1, 1'b0}) begin
      errors++;
      $display("FAIL hold64: got %b want 0010", {st_a, prst_a});
    end
    step(136);
    lock_a = 1'b1;
    step(2);
    checks++;
    if (st_a !== 3'd1) begin
      errors++;
      $display("FAIL lock_sync2: got %0d want 1", st_a);
    end
    step(1);
    checks++;
    if (st_a !== 3'd2) begin
      errors++;
      $display("FAIL lock_sync3: got %0d want 2", st_a);
    end
    step(1023);
    checks++;
    if ({st_a, en_a} !== {3'd2, 4'h0}) begin
      errors++;
      $display("FAIL pre_en0: got %b want 0100000", {st_a, en_a});
    end
    step(1);
    checks++;
    if ({st_a, en_a} !== {3'd3, 4'h1}) begin
      errors++;
      $display("FAIL en0: got %b want 0110001", {st_a, en_a});
    end
    step(16);
    checks++;
    if (en_a !== 4'h3) begin
      errors++;
      $display("FAIL en1: got %h want 3", en_a);
    end
    step(16);
    checks++;
    if (en_a !== 4'h7) begin
      errors++;
      $display("FAIL en2: got %h want 7", en_a);
    end
    step(15);
    checks++;
    if (en_a !== 4'h7) begin
      errors++;
      $display("FAIL pre_en3: got %h want 7", en_a);
    end
    step(1);
    checks++;
    if (en_a !== 4'hF) begin
      errors++;
      $display("FAIL en3: got %h want f", en_a);
    end
    step(15);
    checks++;
    if (snap_a() !== {3'd3, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL pre_run: got %b want 01101111000", snap_a());
    end
    step(1);
    checks++;
    if (snap_a() !== {3'd4, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL run: got %b want 10001111110", snap_a());
    end
  endtask

  task automatic test_lock_loss();
    lock_a = 1'b0;
    step(2);
    checks++;
    if (snap_a() !== {3'd4, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL loss2: got %b want 10001111110", snap_a());
    end
    step(1);
    checks++;
    if ({snap_a(), rel_a} !== {3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL loss3: got %b/%0d want 00010000000/1",
               snap_a(), rel_a);
    end
    lock_a = 1'b1;
    step(63);
    checks++;
    if ({st_a, prst_a} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL rehold: got %b want 0001", {st_a, prst_a});
    end
    step(2);
    checks++;
    if (st_a !== 3'd2) begin
      errors++;
      $display("FAIL restable: got %0d want 2", st_a);
    end
    step(1024);
    checks++;
    if ({st_a, en_a} !== {3'd3, 4'h1}) begin
      errors++;
      $display("FAIL reen0: got %b want 0110001", {st_a, en_a});
    end
    step(63);
    checks++;
    if ({st_a, sys_a} !== {3'd3, 1'b0}) begin
      errors++;
      $display("FAIL pre_rerun: got %b want 0110", {st_a, sys_a});
    end
    step(1);
    checks++;
    if ({st_a, sys_a, rdy_a, rel_a} !== {3'd4, 1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL rerun: got %b want 10011_00000001",
               {st_a, sys_a, rdy_a, rel_a});
    end
  endtask

  task automatic test_unstable();
    rst_n_a = 1'b0;
    step(2);
    @(negedge clk);
    rst_n_a = 1'b1;
    lock_a  = 1'b1;
    step(65);
    checks++;
    if (st_a !== 3'd2) begin
      errors++;
      $display("FAIL ust_enter: got %0d want 2", st_a);
    end
    step(500);
    lock_a = 1'b0;
    step(2);
    checks++;
    if (st_a !== 3'd2) begin
      errors++;
      $display("FAIL ust_hold: got %0d want 2", st_a);
    end
    step(1);
    checks++;
    if (st_a !== 3'd1) begin
      errors++;
      $display("FAIL ust_wait: got %0d want 1", st_a);
    end
    step(2);
    lock_a = 1'b1;
    step(2);
    checks++;
    if (st_a !== 3'd1) begin
      errors++;
      $display("FAIL ust_still_wait: got %0d want 1", st_a);
    end
    step(1);
    checks++;
    if (st_a !== 3'd2) begin
      errors++;
      $display("FAIL ust_restable: got %0d want 2", st_a);
    end
    step(1023);
    checks++;
    if ({st_a, en_a} !== {3'd2, 4'h0}) begin
      errors++;
      $display("FAIL ust_pre_en: got %b want 0100000", {st_a, en_a});
    end
    step(1);
    checks++;
    if ({st_a, en_a, rel_a} !== {3'd3, 4'h1, 8'd0}) begin
      errors++;
      $display("FAIL ust_en0: got %b want 0110001_00000000",
               {st_a, en_a, rel_a});
    end
  endtask

  task automatic test_reset_in_enable();
    step(16);
    checks++;
    if (en_a !== 4'h3) begin
      errors++;
      $display("FAIL rie_en1: got %h want 3", en_a);
    end
    #2;
    rst_n_a = 1'b0;
    #1;
    checks++;
    if (snap_a() !== {3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rie_async: got %b want 00010000000", snap_a());
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    rst_n_b = 1'b1;
    step(63);
    checks++;
    if (prst_b !== 1'b1) begin
      errors++;
      $display("FAIL tmo_h63: got %b want 1", prst_b);
    end
    step(1);
    checks++;
    if (prst_b !== 1'b0) begin
      errors++;
      $display("FAIL tmo_h64: got %b want 0", prst_b);
    end
    step(99);
    checks++;
    if ({prst_b, sys_b} !== 2'b00) begin
      errors++;
      $display("FAIL tmo_w163: got %b want 00", {prst_b, sys_b});
    end
    step(1);
    checks++;
    if ({st_b, prst_b} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL tmo_r164: got %b want 0001", {st_b, prst_b});
    end
    step(63);
    checks++;
    if (prst_b !== 1'b1) begin
      errors++;
      $display("FAIL tmo_h227: got %b want 1", prst_b);
    end
    step(1);
    checks++;
    if (prst_b !== 1'b0) begin
      errors++;
      $display("FAIL tmo_h228: got %b want 0", prst_b);
    end
    step(99);
    checks++;
    if ({prst_b, sys_b} !== 2'b00) begin
      errors++;
      $display("FAIL tmo_w327: got %b want 00", {prst_b, sys_b});
    end
    step(1);
    checks++;
    if (prst_b !== 1'b1) begin
      errors++;
      $display("FAIL tmo_r328: got %b want 1", prst_b);
    end
    step(163);
    checks++;
    if (st_b !== 3'd1) begin
      errors++;
      $display("FAIL tmo_w491: got %0d want 1", st_b);
    end
    step(1);
`ifdef PLL_RETRY_LIMIT_EN
    checks++;
    if (snap_b() !== {3'd5, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL lim_fail: got %b want 10110000001", snap_b());
    end
    step(64);
    checks++;
    if (snap_b() !== {3'd5, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL lim_stay: got %b want 10110000001", snap_b());
    end
    step(200);
    checks++;
    if (snap_b() !== {3'd5, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL lim_stay2: got %b want 10110000001", snap_b());
    end
    rst_n_b = 1'b0;
    #1;
    checks++;
    if (snap_b() !== {3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL lim_clear: got %b want 00010000000", snap_b());
    end
`else
    checks++;
    if (snap_b() !== {3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL tmo_r492: got %b want 00010000000", snap_b());
    end
    step(64);
    checks++;
    if (snap_b() !== {3'd1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL tmo_w556: got %b want 00100000000", snap_b());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_unstable();
    test_reset_in_enable();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
